// File: rtl/riscv_pkg.sv
// Shared RV32I core types: datapath width, canonical NOP, fetch FSM states and
// the IF/ID pipeline register payload that the decode stage also consumes.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
    } if_id_t;
endpackage

// File: rtl/fetch_stage_if.sv
// Handshake/bus bundle between the fetch stage and the rest of the core:
// pipeline control in, instruction-memory port, IF/ID outputs and fault report.
interface fetch_stage_if;
    import riscv_pkg::*;

    logic            stall_i;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic [XLEN-1:0] imem_pc_o;
    logic [XLEN-1:0] imem_instr_i;
    logic            id_valid_o;
    logic [XLEN-1:0] id_pc_o;
    logic [XLEN-1:0] id_pc_plus4_o;
    logic [XLEN-1:0] id_instr_o;
    logic            fault_o;
    logic [XLEN-1:0] fault_pc_o;

    modport master (
        output stall_i, redirect_i, redirect_pc_i, imem_instr_i,
        input  imem_pc_o, id_valid_o, id_pc_o, id_pc_plus4_o, id_instr_o,
               fault_o, fault_pc_o
    );

    modport slave (
        input  stall_i, redirect_i, redirect_pc_i, imem_instr_i,
        output imem_pc_o, id_valid_o, id_pc_o, id_pc_plus4_o, id_instr_o,
               fault_o, fault_pc_o
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Flush turns the slot into a NOP bubble; kill only
// drops valid so the last fetched PC/word stay visible for debug.
module if_id_reg
    import riscv_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_load,
    input  logic   i_flush,
    input  logic   i_kill,
    input  if_id_t i_data,
    output if_id_t o_data
);
    if_id_t r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= if_id_t'{valid: 1'b0, pc: '0, pc_plus4: XLEN'(4), instr: NOP_INSTR};
        end else if (i_flush) begin
            r_data.valid <= 1'b0;
            r_data.instr <= NOP_INSTR;
        end else if (i_kill) begin
            r_data.valid <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_data = r_data;
endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, drives the combinational-read
// instruction memory, fills IF/ID, and traps on misaligned/out-of-range PCs.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int              NUM_INST = 120,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input logic          clk,
    input logic          rst,
    fetch_stage_if.slave bus
);
    localparam int              IMEM_BYTES = NUM_INST * 4;
    localparam logic [XLEN-1:0] LAST_PC    = XLEN'(IMEM_BYTES - 4);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic            r_fault;
    logic [XLEN-1:0] r_fault_pc;
    logic            w_fault_set;
    logic [XLEN-1:0] w_fault_pc_next;
    logic            w_load;
    logic            w_flush;
    logic            w_kill;
    logic            w_target_legal;
    logic [XLEN-1:0] w_pc_plus4;
    if_id_t          w_id_in;
    if_id_t          w_id_out;

    // Unsigned compare: a wrapped PC can never look legal again.
    assign w_target_legal = (bus.redirect_pc_i[1:0] == 2'b00) && (bus.redirect_pc_i <= LAST_PC);
    assign w_pc_plus4     = r_pc + XLEN'(4);

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_fault_set     = 1'b0;
        w_fault_pc_next = r_fault_pc;
        w_load          = 1'b0;
        w_flush         = 1'b0;
        w_kill          = 1'b0;
        case (r_state)
            RUN: begin
                if (bus.redirect_i) begin
                    if (w_target_legal) begin
                        w_pc_next = bus.redirect_pc_i;
                        w_flush   = 1'b1;
                    end else begin
                        w_state_next    = FAULT;
                        w_fault_set     = 1'b1;
                        w_fault_pc_next = bus.redirect_pc_i;
                        w_kill          = 1'b1;
                    end
                end else if (bus.stall_i) begin
                    w_pc_next = r_pc;
                end else if (r_pc > LAST_PC) begin
                    w_state_next    = FAULT;
                    w_fault_set     = 1'b1;
                    w_fault_pc_next = r_pc;
                    w_kill          = 1'b1;
                end else begin
                    w_load    = 1'b1;
                    w_pc_next = w_pc_plus4;
                end
            end
            default: begin
                w_state_next = FAULT;
            end
        endcase
    end

    // The memory word is only forwarded into IF/ID when actually loaded.
    assign w_id_in = if_id_t'{valid: 1'b1, pc: r_pc, pc_plus4: w_pc_plus4, instr: bus.imem_instr_i};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_pc       <= RESET_PC;
            r_fault    <= 1'b0;
            r_fault_pc <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_fault_set) begin
                r_fault    <= 1'b1;
                r_fault_pc <= w_fault_pc_next;
            end
        end
    end

    if_id_reg u_if_id (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_kill  (w_kill),
        .i_data  (w_id_in),
        .o_data  (w_id_out)
    );

    assign bus.imem_pc_o     = r_pc;
    assign bus.id_valid_o    = w_id_out.valid;
    assign bus.id_pc_o       = w_id_out.pc;
    assign bus.id_pc_plus4_o = w_id_out.pc_plus4;
    assign bus.id_instr_o    = w_id_out.instr;
    assign bus.fault_o       = r_fault;
    assign bus.fault_pc_o    = r_fault_pc;
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the single-issue RV32I core. It owns the program counter and drives it to the byte-addressed, combinational-read instruction memory. It captures the returned 32-bit word into the IF/ID pipeline register for the decoder. It also handles stall, branch/jump redirect with flush, and PC fault detection (misaligned or out-of-range).

Parameters:
XLEN, 32, data/address width
NUM_INST, 120, instruction memory capacity in words
IMEM_BYTES, NUM_INST*4, instruction memory size in bytes (480 at default)
RESET_PC, 32'h0000_0000, PC value after reset

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
stall_i  in  1  hold PC and IF/ID contents
redirect_i  in  1  branch/jump taken; load redirect_pc_i and flush IF/ID
redirect_pc_i  in  XLEN  redirect target (byte address)
imem_pc_o  out  XLEN  address to instruction memory PC input
imem_instr_i  in  XLEN  instruction word from memory (same cycle, combinational)
id_valid_o  out  1  IF/ID holds a real instruction
id_pc_o  out  XLEN  PC of the held instruction
id_pc_plus4_o  out  XLEN  id_pc_o + 4 (link address)
id_instr_o  out  XLEN  held instruction word
fault_o  out  1  sticky fetch fault
fault_pc_o  out  XLEN  offending PC or target

Behaviour:
- One clock, synchronous active-high reset; all state updates on rising clk.
- Reset values:
  - pc = RESET_PC; imem_pc_o = RESET_PC
  - id_valid_o = 0, id_pc_o = 0, id_pc_plus4_o = 4, id_instr_o = 32'h0000_0013 (NOP)
  - fault_o = 0, fault_pc_o = 0
  - state = RUN
- imem_pc_o = pc, combinationally, at all times.
- States: RUN, FAULT. Only rst leaves FAULT.
- RUN, per cycle, first matching rule wins:
  1. redirect_i=1, target legal (target[1:0]=0 and target <= IMEM_BYTES-4): pc <= target; id_valid <= 0; id_instr <= NOP; id_pc/id_pc_plus4 unchanged. Redirect overrides stall_i.
  2. redirect_i=1, target illegal: state <= FAULT; fault_o <= 1; fault_pc_o <= target; id_valid <= 0; pc unchanged.
  3. stall_i=1: pc and all id_* hold.
  4. pc > IMEM_BYTES-4: state <= FAULT; fault_o <= 1; fault_pc_o <= pc; id_valid <= 0; no capture.
  5. Otherwise: id_instr <= imem_instr_i; id_pc <= pc; id_pc_plus4 <= pc+4; id_valid <= 1; pc <= pc+4.
- Latency: the word at PC appears on id_* one cycle after PC is presented. A redirect costs exactly one bubble cycle.
- FAULT: pc holds; id_valid_o = 0; stall_i and redirect_i ignored; fault_o and fault_pc_o hold.
- PC arithmetic: XLEN-bit modulo 2^XLEN. Range check uses an unsigned compare against IMEM_BYTES-4, so no wrap into the legal range is possible.
- rst asserted mid-stall, mid-redirect or in FAULT: the next edge restores every reset value; redirect_i and stall_i are ignored during that cycle.
- imem_instr_i is sampled only in rule 5; X on it elsewhere must not propagate.

Decomposition:
- riscv_pkg (shared):
  - XLEN
  - NOP_INSTR = 32'h0000_0013
  - fetch_state_t enum {RUN, FAULT}
  - if_id_t struct {valid, pc, pc_plus4, instr}, reused by the decode stage
- Sub-module if_id_reg: holds if_id_t and provides load/hold/flush controls. fetch_stage contains the PC logic, legality checks and FSM.

Test Plan:
- Reset, then release with words 0x00500093 at 0x0 and 0x00A00113 at 0x4 -> imem_pc_o=0, id_valid_o=0, id_instr_o=0x13 during reset. First edge: id_pc_o=0, id_instr_o=0x00500093. Second edge: id_pc_o=4, id_pc_plus4_o=8, id_instr_o=0x00A00113.
- stall_i=1 for 2 cycles at pc=0x8 -> imem_pc_o stays 0x8, id_pc_o stays 0x4 with valid=1. After release, next edge gives id_pc_o=0x8.
- redirect_i=1, redirect_pc_i=0x40, with stall_i=1 in the same cycle -> next cycle imem_pc_o=0x40, id_valid_o=0. Following edge: id_pc_o=0x40, valid=1.
- redirect_pc_i=0x42 (misaligned), then separately 0x1E4 (out of range) -> fault_o=1 with fault_pc_o=0x42 (resp. 0x1E4), id_valid_o=0, imem_pc_o unchanged. Later redirects are ignored until rst.
- Sequential run from 0x1D8 -> id_pc_o=0x1D8, then 0x1DC valid. When pc=0x1E0: fault_o=1, fault_pc_o=0x1E0, id_valid_o=0.
- rst pulsed while in FAULT -> next edge: fault_o=0, imem_pc_o=RESET_PC, id_valid_o=0. Normal fetch resumes at 0x0.
